// File: rtl/i2s_slave_rx.sv
// I2S target-side receiver: oversamples sclk/lrclk/sdin in the clk domain and presents stereo pairs on dvalid/dready.
// Define I2S_RX_TIMEOUT_EN to add a loss-of-sclk watchdog that drops lock after TIMEOUT idle clk cycles.
module i2s_slave_rx #(
  parameter int DATA_W      = 24,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              lrclk_in,
  input  logic              sdin,
  output logic [DATA_W-1:0] ldata,
  output logic [DATA_W-1:0] rdata,
  output logic              dvalid,
  input  logic              dready,
  output logic              locked,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(SLOT_W + 2);

  typedef enum logic [1:0] {UNLOCKED, SYNC, LEFT, RIGHT} state_t;

  if (SLOT_W < DATA_W + 1 || SYNC_STAGES < 2 || TIMEOUT < 1) begin : gBadParams
    $error("i2s_slave_rx: invalid parameter combination");
  end

  logic [SYNC_STAGES-1:0] sclkSync_q, lrSync_q, sdSync_q;
  logic                   sclkPrev_q, rise_q, lr_q, sd_q, lrPrev_q;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cntInc;
  logic [DATA_W-1:0]      shiftL_q, shiftR_q, holdL_q, ldata_q, rdata_q;
  logic                   dvalid_q, locked_q, frameErr_q, overrun_q;
  logic                   boundary, lenOk;

`ifdef I2S_RX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q;
  logic            wdHit;
`endif

  // Pin synchronizers plus one stage that turns the sclk edge into a strobe, with lr/sd aligned to it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclkSync_q <= '0;
      lrSync_q   <= '0;
      sdSync_q   <= '0;
      sclkPrev_q <= 1'b0;
      rise_q     <= 1'b0;
      lr_q       <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk_in};
      lrSync_q   <= {lrSync_q[SYNC_STAGES-2:0], lrclk_in};
      sdSync_q   <= {sdSync_q[SYNC_STAGES-2:0], sdin};
      sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
      rise_q     <= sclkSync_q[SYNC_STAGES-1] & ~sclkPrev_q;
      lr_q       <= lrSync_q[SYNC_STAGES-1];
      sd_q       <= sdSync_q[SYNC_STAGES-1];
    end
  end

  assign boundary = rise_q && (lr_q != lrPrev_q);
  assign lenOk    = (cnt_q == CNT_W'(SLOT_W - 1));
  assign cntInc   = (cnt_q == CNT_W'(SLOT_W + 1)) ? cnt_q : cnt_q + 1'b1;

`ifdef I2S_RX_TIMEOUT_EN
  assign wdHit = !rise_q && (wdog_q == WD_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= UNLOCKED;
      cnt_q      <= '0;
      lrPrev_q   <= 1'b0;
      shiftL_q   <= '0;
      shiftR_q   <= '0;
      holdL_q    <= '0;
      ldata_q    <= '0;
      rdata_q    <= '0;
      dvalid_q   <= 1'b0;
      locked_q   <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef I2S_RX_TIMEOUT_EN
      wdog_q     <= '0;
`endif
    end else begin
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
      if (dvalid_q && dready) dvalid_q <= 1'b0;

      if (rise_q) begin
        lrPrev_q <= lr_q;
        if (boundary) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cntInc;
          if (cntInc <= CNT_W'(DATA_W)) begin
            if (lr_q) shiftR_q <= {shiftR_q[DATA_W-2:0], sd_q};
            else      shiftL_q <= {shiftL_q[DATA_W-2:0], sd_q};
          end
        end

        // Slot boundaries drive the framing; a wrong slot length throws away the partial pair.
        unique case (state_q)
          UNLOCKED: state_q <= SYNC;
          SYNC: begin
            if (boundary && !lr_q) state_q <= LEFT;
          end
          LEFT: begin
            if (boundary) begin
              if (lenOk) begin
                holdL_q  <= shiftL_q;
                locked_q <= 1'b1;
                state_q  <= RIGHT;
              end else begin
                frameErr_q <= 1'b1;
                locked_q   <= 1'b0;
                state_q    <= SYNC;
              end
            end
          end
          RIGHT: begin
            if (boundary) begin
              if (lenOk) begin
                state_q <= LEFT;
                if (!dvalid_q || dready) begin
                  ldata_q  <= holdL_q;
                  rdata_q  <= shiftR_q;
                  dvalid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end else begin
                frameErr_q <= 1'b1;
                locked_q   <= 1'b0;
                state_q    <= SYNC;
              end
            end
          end
          default: state_q <= UNLOCKED;
        endcase
      end

`ifdef I2S_RX_TIMEOUT_EN
      // A stalled sclk drops lock but leaves any pending output pair for the consumer.
      if (rise_q) wdog_q <= '0;
      else if (wdog_q != WD_W'(TIMEOUT)) wdog_q <= wdog_q + 1'b1;
      if (wdHit) begin
        locked_q <= 1'b0;
        state_q  <= UNLOCKED;
        cnt_q    <= '0;
        shiftL_q <= '0;
        shiftR_q <= '0;
      end
`endif
    end
  end

  assign ldata     = ldata_q;
  assign rdata     = rdata_q;
  assign dvalid    = dvalid_q;
  assign locked    = locked_q;
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;

endmodule
